// File: rtl/mitchell_mult_ctrl.sv
// Sequential Mitchell logarithmic multiplier for 8x8 unsigned operands.
// One shared leading-one encoder is used for both operands; results leave through a valid/ready handshake.

module mitchell_encoder (
  input  logic [7:0] a,
  output logic [9:0] c
);
  logic [2:0] k;
  logic [7:0] norm;

  // c = {k, mantissa}: k is the leading-one index, and the mantissa is the bits below it, left-aligned
  always_comb begin
    k = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (a[i]) k = 3'(i);
    end
    norm = a << (3'd7 - k);
    c    = (a == 8'd0) ? 10'd0 : {k, norm[6:0]};
  end
endmodule

module mitchell_mult_ctrl #(
  parameter bit ZERO_BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  op_a,
  input  logic [7:0]  op_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] product,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, ENC_A, ENC_B, SUM, ANTI, DONE} state_t;

  state_t      state;
  logic [7:0]  ra, rb, enc_in;
  logic [9:0]  la, lb, enc_c;
  logic [10:0] s;
  logic        z;
  logic [22:0] anti_shift;
  logic        op_zero;

  mitchell_encoder u_enc (
    .a (enc_in),
    .c (enc_c)
  );

  always_comb begin
    enc_in = 8'd0;
    if (state == ENC_A) enc_in = ra;
    else if (state == ENC_B) enc_in = rb;
  end

  // Antilog: restore the hidden one, shift by the integer log, and drop the 7 fraction bits
  assign anti_shift = {15'd0, 1'b1, s[6:0]} << s[10:7];
  assign op_zero    = (op_a == 8'd0) || (op_b == 8'd0);
  assign in_ready   = (state == IDLE) && !rst;
  assign busy       = (state != IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      product   <= 16'd0;
      ra        <= 8'd0;
      rb        <= 8'd0;
      la        <= 10'd0;
      lb        <= 10'd0;
      s         <= 11'd0;
      z         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ra <= op_a;
            rb <= op_b;
            z  <= op_zero;
            if (op_zero && ZERO_BYPASS) begin
              product <= 16'd0;
              state   <= DONE;
            end else begin
              state <= ENC_A;
            end
          end
        end
        ENC_A: begin
          la    <= enc_c;
          state <= ENC_B;
        end
        ENC_B: begin
          lb    <= enc_c;
          state <= SUM;
        end
        SUM: begin
          s     <= {1'b0, la} + {1'b0, lb};
          state <= ANTI;
        end
        ANTI: begin
          product   <= z ? 16'd0 : anti_shift[22:7];
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          // The bypass path arrives here with out_valid low and raises it one cycle later
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mitchell_mult_ctrl.sv
// Directed bench for mitchell_mult_ctrl; one instance with zero bypass and one without share the inputs.
module tb_mitchell_mult_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready;
  logic [7:0]  op_a, op_b;
  logic        in_ready_b, out_valid_b, busy_b;
  logic        in_ready_nb, out_valid_nb, busy_nb;
  logic [15:0] product_b, product_nb;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  mitchell_mult_ctrl dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .op_a(op_a), .op_b(op_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .product(product_b), .busy(busy_b)
  );

  mitchell_mult_ctrl #(.ZERO_BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_nb),
    .op_a(op_a), .op_b(op_b), .out_valid(out_valid_nb), .out_ready(out_ready),
    .product(product_nb), .busy(busy_nb)
  );

  // Reference: integer log2, linear mantissa, sum, then linear antilog truncated to an integer
  function automatic logic [15:0] model(input int a, input int b);
    int ka, kb, fa, fb, sum, kk, ff;
    longint m;
    if (a == 0 || b == 0) return 16'd0;
    ka = 0; kb = 0;
    for (int i = 0; i < 8; i++) begin
      if (a >= (1 << i)) ka = i;
      if (b >= (1 << i)) kb = i;
    end
    fa = ((a - (1 << ka)) * 128) / (1 << ka);
    fb = ((b - (1 << kb)) * 128) / (1 << kb);
    sum = ka * 128 + fa + kb * 128 + fb;
    kk = sum / 128;
    ff = sum % 128;
    m = (longint'(128 + ff) << kk) >> 7;
    return m[15:0];
  endfunction

  // Runs one transaction on both instances; latency counts edges after the accept edge
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        output logic [15:0] pb, output logic [15:0] pnb,
                        output int lb, output int lnb);
    int n;
    lb = -1; lnb = -1; pb = 16'hxxxx; pnb = 16'hxxxx;
    out_ready = 1'b0; op_a = a; op_b = b; in_valid = 1'b1;
    n = 0;
    while (!(in_ready_b && in_ready_nb) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int e = 1; e <= 20 && (lb < 0 || lnb < 0); e++) begin
      @(posedge clk); #1;
      if (lb < 0 && out_valid_b) begin lb = e; pb = product_b; end
      if (lnb < 0 && out_valid_nb) begin lnb = e; pnb = product_nb; end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op_a = 8'd0; op_b = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready_b !== 1'b0) begin failures++; $display("[TB] FAIL reset_in_ready got=%b want=0", in_ready_b); end
    checks++; if (busy_b !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b want=0", busy_b); end
    checks++; if (out_valid_b !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid_b); end
    checks++; if (product_b !== 16'd0) begin failures++; $display("[TB] FAIL reset_product got=%0d want=0", product_b); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready_b !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_in_ready got=%b want=1", in_ready_b); end
    checks++; if (in_ready_nb !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_in_ready_nb got=%b want=1", in_ready_nb); end
  endtask

  task automatic test_basic;
    logic [7:0]  va [5] = '{8'd3, 8'd255, 8'd2, 8'd3, 8'd1};
    logic [7:0]  vb [5] = '{8'd5, 8'd255, 8'd2, 8'd3, 8'd1};
    logic [15:0] ve [5] = '{16'd14, 16'd65024, 16'd4, 16'd8, 16'd1};
    logic [15:0] pb, pnb;
    int lb, lnb;
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], pb, pnb, lb, lnb);
      checks++; if (pb !== ve[i]) begin failures++; $display("[TB] FAIL basic_product %0d*%0d got=%0d want=%0d", va[i], vb[i], pb, ve[i]); end
      checks++; if (lb != 4) begin failures++; $display("[TB] FAIL basic_latency %0d*%0d got=%0d want=4", va[i], vb[i], lb); end
      checks++; if (pnb !== ve[i]) begin failures++; $display("[TB] FAIL basic_product_nb %0d*%0d got=%0d want=%0d", va[i], vb[i], pnb, ve[i]); end
      checks++; if (lnb != 4) begin failures++; $display("[TB] FAIL basic_latency_nb %0d*%0d got=%0d want=4", va[i], vb[i], lnb); end
    end
  endtask

  task automatic test_hold;
    op_a = 8'd3; op_b = 8'd5; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid_b !== 1'b0) begin failures++; $display("[TB] FAIL hold_early_valid got=%b want=0", out_valid_b); end
    @(posedge clk); #1;
    checks++; if (out_valid_b !== 1'b1) begin failures++; $display("[TB] FAIL hold_valid_n4 got=%b want=1", out_valid_b); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid_b !== 1'b1 || product_b !== 16'd14) begin
        failures++; $display("[TB] FAIL hold_stable cycle %0d got valid=%b product=%0d want valid=1 product=14", i, out_valid_b, product_b);
      end
    end
    checks++; if (in_ready_b !== 1'b0) begin failures++; $display("[TB] FAIL hold_in_ready_done got=%b want=0", in_ready_b); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_valid_b !== 1'b0 || in_ready_b !== 1'b1) begin
      failures++; $display("[TB] FAIL hold_release got valid=%b ready=%b want valid=0 ready=1", out_valid_b, in_ready_b);
    end
  endtask

  task automatic test_zero;
    logic [15:0] pb, pnb;
    int lb, lnb;
    run_op(8'd0, 8'd200, pb, pnb, lb, lnb);
    checks++; if (pb !== 16'd0) begin failures++; $display("[TB] FAIL zero_product_bypass got=%0d want=0", pb); end
    checks++; if (lb != 1) begin failures++; $display("[TB] FAIL zero_latency_bypass got=%0d want=1", lb); end
    checks++; if (pnb !== 16'd0) begin failures++; $display("[TB] FAIL zero_product_full got=%0d want=0", pnb); end
    checks++; if (lnb != 4) begin failures++; $display("[TB] FAIL zero_latency_full got=%0d want=4", lnb); end
    run_op(8'd37, 8'd0, pb, pnb, lb, lnb);
    checks++; if (pb !== 16'd0 || lb != 1) begin failures++; $display("[TB] FAIL zero_b_bypass got product=%0d lat=%0d want product=0 lat=1", pb, lb); end
    checks++; if (pnb !== 16'd0 || lnb != 4) begin failures++; $display("[TB] FAIL zero_b_full got product=%0d lat=%0d want product=0 lat=4", pnb, lnb); end
  endtask

  task automatic test_reset_abort;
    logic [15:0] pb, pnb;
    int lb, lnb;
    logic seen;
    op_a = 8'd4; op_b = 8'd6; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy_b !== 1'b1) begin failures++; $display("[TB] FAIL abort_busy_before got=%b want=1", busy_b); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy_b !== 1'b0 || in_ready_b !== 1'b0 || out_valid_b !== 1'b0) begin
      failures++; $display("[TB] FAIL abort_during_reset got busy=%b ready=%b valid=%b want 0 0 0", busy_b, in_ready_b, out_valid_b);
    end
    rst = 1'b0;
    #1;
    checks++; if (in_ready_b !== 1'b1) begin failures++; $display("[TB] FAIL abort_in_ready got=%b want=1", in_ready_b); end
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid_b || out_valid_nb) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("[TB] FAIL abort_no_output got=%b want=0", seen); end
    run_op(8'd4, 8'd6, pb, pnb, lb, lnb);
    checks++; if (pb !== 16'd24 || lb != 4) begin failures++; $display("[TB] FAIL abort_next_op got product=%0d lat=%0d want product=24 lat=4", pb, lb); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] va [3] = '{8'd7, 8'd200, 8'd128};
    logic [7:0] vb [3] = '{8'd9, 8'd13, 8'd255};
    logic [15:0] want;
    int idx, cyc;
    logic viol;
    idx = 0; viol = 1'b0; cyc = 0;
    op_a = va[0]; op_b = vb[0]; in_valid = 1'b1; out_ready = 1'b1;
    while (idx < 3 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (busy_b && in_ready_b) viol = 1'b1;
      if (out_valid_b) begin
        want = model(int'(va[idx]), int'(vb[idx]));
        checks++; if (product_b !== want) begin
          failures++; $display("[TB] FAIL b2b_product %0d*%0d got=%0d want=%0d", va[idx], vb[idx], product_b, want);
        end
        idx++;
        if (idx < 3) begin op_a = va[idx]; op_b = vb[idx]; end
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (idx != 3) begin failures++; $display("[TB] FAIL b2b_completions got=%0d want=3", idx); end
    checks++; if (viol !== 1'b0) begin failures++; $display("[TB] FAIL b2b_in_ready_while_busy got=%b want=0", viol); end
    checks++; if (busy_b !== 1'b0) begin failures++; $display("[TB] FAIL b2b_idle_after got=%b want=0", busy_b); end
  endtask

  task automatic test_sweep;
    logic [15:0] pb, pnb, want;
    int lb, lnb;
    for (int a = 1; a <= 255; a += 6) begin
      for (int b = 1; b <= 255; b += 9) begin
        run_op(8'(a), 8'(b), pb, pnb, lb, lnb);
        want = model(a, b);
        checks++; if (pb !== want) begin failures++; $display("[TB] FAIL sweep_model %0d*%0d got=%0d want=%0d", a, b, pb, want); end
        checks++; if (int'(pb) > a * b) begin failures++; $display("[TB] FAIL sweep_bound %0d*%0d got=%0d want<=%0d", a, b, pb, a * b); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_hold;
    test_zero;
    test_reset_abort;
    test_back_to_back;
    test_sweep;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
